// File: rtl/mgmt_irq_ctrl.sv
// Interrupt front end: sync, glitch filter, edge/level pending, mask; 4+FILT_CYCLES cycles pad->irq_out.
// Register port has no backpressure: every reg_we/reg_re strobe completes at its own clock edge.
module mgmt_irq_ctrl #(
  parameter int NUM_SRC     = 4,
  parameter int FILT_CYCLES = 4
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [NUM_SRC-1:0] irq_in,
  input  logic [1:0]         reg_addr,
  input  logic               reg_we,
  input  logic               reg_re,
  input  logic [31:0]        reg_wdata,
  output logic [31:0]        reg_rdata,
  output logic [NUM_SRC-1:0] irq_out,
  output logic               irq_any
);

  localparam int CW = (FILT_CYCLES > 1) ? $clog2(FILT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(FILT_CYCLES - 1);

  localparam logic [1:0] ADDR_ENABLE  = 2'd0;
  localparam logic [1:0] ADDR_MODE    = 2'd1;
  localparam logic [1:0] ADDR_PENDING = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  logic [NUM_SRC-1:0] sync1_q, sync2_q;
  logic [NUM_SRC-1:0] filt_q, filt_d, filt_prev_q;
  logic [CW-1:0]      cnt_q [NUM_SRC];
  logic [CW-1:0]      cnt_d [NUM_SRC];
  logic [NUM_SRC-1:0] enable_q, enable_d;
  logic [NUM_SRC-1:0] mode_q, mode_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] irq_out_q;
  logic               irq_any_q;
  logic [31:0]        rdata_q, rdata_d;
  logic [31:0]        rd_mux;
  logic [NUM_SRC-1:0] wr_val, w1c, rise;
  logic               unused_wdata;

  assign wr_val       = reg_wdata[NUM_SRC-1:0];
  assign unused_wdata = ^reg_wdata;
  assign rise         = filt_q & ~filt_prev_q;

  // A level change is accepted only after FILT_CYCLES consecutive disagreeing samples.
  always_comb begin
    filt_d = filt_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != filt_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          filt_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    enable_d = enable_q;
    mode_d   = mode_q;
    w1c      = '0;
    if (reg_we) begin
      case (reg_addr)
        ADDR_ENABLE:  enable_d = wr_val;
        ADDR_MODE:    mode_d   = wr_val;
        ADDR_PENDING: w1c      = wr_val;
        default:      ;
      endcase
    end
    // Edge mode: a new rising edge beats a same-cycle W1C. Level mode mirrors f.
    for (int i = 0; i < NUM_SRC; i++) begin
      pend_d[i] = mode_q[i] ? ((pend_q[i] & ~w1c[i]) | rise[i]) : filt_q[i];
    end
  end

  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      ADDR_ENABLE:  rd_mux[NUM_SRC-1:0] = enable_q;
      ADDR_MODE:    rd_mux[NUM_SRC-1:0] = mode_q;
      ADDR_PENDING: rd_mux[NUM_SRC-1:0] = pend_q;
      ADDR_STATUS:  rd_mux[NUM_SRC-1:0] = filt_q;
      default:      rd_mux = '0;
    endcase
    rdata_d = reg_re ? rd_mux : rdata_q;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      filt_q      <= '0;
      filt_prev_q <= '0;
      for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= '0;
      enable_q    <= '0;
      mode_q      <= '1;
      pend_q      <= '0;
      irq_out_q   <= '0;
      irq_any_q   <= 1'b0;
      rdata_q     <= '0;
    end else begin
      sync1_q     <= irq_in;
      sync2_q     <= sync1_q;
      filt_q      <= filt_d;
      filt_prev_q <= filt_q;
      for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= cnt_d[i];
      enable_q    <= enable_d;
      mode_q      <= mode_d;
      pend_q      <= pend_d;
      irq_out_q   <= pend_q & enable_q;
      irq_any_q   <= |(pend_q & enable_q);
      rdata_q     <= rdata_d;
    end
  end

  assign reg_rdata = rdata_q;
  assign irq_out   = irq_out_q;
  assign irq_any   = irq_any_q;

endmodule

// File: tb/tb_mgmt_irq_ctrl.sv
// Scoreboard bench for mgmt_irq_ctrl: stimulus pushes cycle-stamped expectations, a negedge monitor pops and compares.
module tb_mgmt_irq_ctrl;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [3:0]  irq_in = '0;
  logic [1:0]  reg_addr = '0;
  logic        reg_we = 1'b0;
  logic        reg_re = 1'b0;
  logic [31:0] reg_wdata = '0;
  logic [31:0] reg_rdata;
  logic [3:0]  irq_out;
  logic        irq_any;

  mgmt_irq_ctrl #(.NUM_SRC(4), .FILT_CYCLES(4)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .irq_in    (irq_in),
    .reg_addr  (reg_addr),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_wdata (reg_wdata),
    .reg_rdata (reg_rdata),
    .irq_out   (irq_out),
    .irq_any   (irq_any)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          cyc;
    logic [3:0]  irq;
    logic        any;
    bit          has_rd;
    logic [31:0] rd;
  } exp_t;

  exp_t        expq[$];
  logic [31:0] rdq[$];
  logic        rd_vld = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  always @(posedge clock) begin
    cyc    <= cyc + 1;
    rd_vld <= reg_re;
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: register reads complete one edge after reg_re; irq expectations are cycle-stamped.
  always @(negedge clock) begin
    exp_t e;
    if (rd_vld) begin
      if (rdq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got 0x%08h with no expected read at cycle %0d", reg_rdata, cyc);
      end else begin
        check("reg_rdata", reg_rdata, rdq.pop_front());
      end
    end
    while (expq.size() > 0 && expq[0].cyc <= cyc) begin
      e = expq.pop_front();
      if (e.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_check: expectation for cycle %0d seen at cycle %0d", e.cyc, cyc);
      end else begin
        check("irq_out", 32'(irq_out), 32'(e.irq));
        check("irq_any", 32'(irq_any), 32'(e.any));
        if (e.has_rd) check("rdata_reset", reg_rdata, e.rd);
      end
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic wr(logic [1:0] a, logic [31:0] d);
    reg_addr  = a;
    reg_wdata = d;
    reg_we    = 1'b1;
    tick();
    reg_we    = 1'b0;
  endtask

  task automatic rd(logic [1:0] a, logic [31:0] exp);
    reg_addr = a;
    reg_re   = 1'b1;
    rdq.push_back(exp);
    tick();
    reg_re   = 1'b0;
  endtask

  task automatic rw(logic [1:0] a, logic [31:0] d, logic [31:0] exp);
    reg_addr  = a;
    reg_wdata = d;
    reg_we    = 1'b1;
    reg_re    = 1'b1;
    rdq.push_back(exp);
    tick();
    reg_we    = 1'b0;
    reg_re    = 1'b0;
  endtask

  task automatic expect_irq(int off, logic [3:0] v);
    exp_t e;
    e.cyc    = cyc + off;
    e.irq    = v;
    e.any    = |v;
    e.has_rd = 1'b0;
    e.rd     = '0;
    expq.push_back(e);
  endtask

  task automatic expect_reset_now();
    exp_t e;
    e.cyc    = cyc;
    e.irq    = '0;
    e.any    = 1'b0;
    e.has_rd = 1'b1;
    e.rd     = '0;
    expq.push_back(e);
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    // Reset state, checked while resetn is still low.
    tick(2);
    expect_reset_now();
    tick();
    resetn = 1'b1;
    rd(2'd0, 32'h0);
    rd(2'd1, 32'hF);
    rd(2'd2, 32'h0);
    rd(2'd3, 32'h0);

    // 1. Edge mode basic latency and W1C.
    wr(2'd0, 32'h1);
    wr(2'd1, 32'h1);
    irq_in[0] = 1'b1;
    expect_irq(6, 4'h0);
    expect_irq(7, 4'h0);
    expect_irq(8, 4'h1);
    tick(8);
    rd(2'd2, 32'h1);
    rd(2'd3, 32'h1);
    expect_irq(1, 4'h1);
    expect_irq(2, 4'h0);
    expect_irq(5, 4'h0);
    wr(2'd2, 32'h1);
    tick(4);
    rd(2'd2, 32'h0);

    // 2. Glitch rejection: 3-cycle pulse filtered, 4-cycle pulse accepted.
    irq_in[0] = 1'b0;
    tick(10);
    rd(2'd3, 32'h0);
    irq_in[0] = 1'b1;
    expect_irq(4, 4'h0);
    expect_irq(8, 4'h0);
    expect_irq(12, 4'h0);
    tick(3);
    irq_in[0] = 1'b0;
    tick(9);
    rd(2'd3, 32'h0);
    rd(2'd2, 32'h0);
    irq_in[0] = 1'b1;
    expect_irq(7, 4'h0);
    expect_irq(8, 4'h1);
    tick(4);
    irq_in[0] = 1'b0;
    tick(8);
    rd(2'd2, 32'h1);
    rd(2'd3, 32'h0);
    expect_irq(2, 4'h0);
    wr(2'd2, 32'h1);
    tick(2);

    // 3. Level mode: follows f, W1C ignored.
    wr(2'd1, 32'h0);
    tick(2);
    irq_in[0] = 1'b1;
    expect_irq(7, 4'h0);
    expect_irq(8, 4'h1);
    tick(8);
    expect_irq(1, 4'h1);
    expect_irq(3, 4'h1);
    wr(2'd2, 32'h1);
    tick(2);
    rd(2'd2, 32'h1);
    irq_in[0] = 1'b0;
    expect_irq(7, 4'h1);
    expect_irq(8, 4'h0);
    tick(10);

    // 4. Masking, enable, and set-beats-clear race on source 2.
    wr(2'd1, 32'hF);
    wr(2'd0, 32'h0);
    irq_in[2] = 1'b1;
    expect_irq(8, 4'h0);
    expect_irq(10, 4'h0);
    tick(10);
    rd(2'd2, 32'h4);
    expect_irq(1, 4'h0);
    expect_irq(2, 4'h4);
    wr(2'd0, 32'h4);
    tick(2);
    irq_in[2] = 1'b0;
    tick(10);
    expect_irq(1, 4'h4);
    expect_irq(2, 4'h0);
    wr(2'd2, 32'h4);
    tick(2);
    irq_in[2] = 1'b1;
    expect_irq(7, 4'h0);
    expect_irq(8, 4'h4);
    expect_irq(10, 4'h4);
    tick(6);
    wr(2'd2, 32'h4);
    tick(3);
    rd(2'd2, 32'h4);

    // 5. Register port width masking, read-before-write, STATUS read-only.
    wr(2'd0, 32'hFFFF_FFFF);
    rd(2'd0, 32'h0000_000F);
    rw(2'd1, 32'h5, 32'hF);
    rd(2'd1, 32'h5);
    wr(2'd3, 32'h0);
    rd(2'd3, 32'h4);
    rd(2'd2, 32'h4);
    expect_irq(1, 4'h4);
    tick(1);

    // 6. Async reset mid-pend, line held high through release.
    wr(2'd1, 32'hF);
    irq_in = 4'hF;
    expect_irq(8, 4'hF);
    tick(10);
    rd(2'd2, 32'hF);
    tick();
    expect_reset_now();
    #1 resetn = 1'b0;
    #5 resetn = 1'b1;
    rd(2'd0, 32'h0);
    rd(2'd1, 32'hF);
    rd(2'd2, 32'h0);
    rd(2'd3, 32'h0);
    rd(2'd2, 32'h0);
    rd(2'd3, 32'h0);
    rd(2'd2, 32'h0);
    rd(2'd2, 32'hF);
    rd(2'd3, 32'hF);
    expect_irq(1, 4'h0);
    tick(3);

    if (expq.size() != 0 || rdq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover: got %0d irq and %0d read expectations pending, expected 0", expq.size(), rdq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
